// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register with valid/ready handshake,
// freeze/flush control and an optional two-entry skid buffer.
module pipe_stage_reg #(
   parameter int                 DATA_W    = 64,
   parameter int                 SKID      = 1,
   parameter logic [DATA_W-1:0]  RESET_VAL = '0,
   parameter int                 CNT_W     = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              freeze,
   input  logic              valid_in,
   input  logic [DATA_W-1:0] data_in,
   output logic              ready_out,
   output logic              valid_out,
   output logic [DATA_W-1:0] data_out,
   input  logic              ready_in,
   output logic [1:0]        count,
   output logic [CNT_W-1:0]  drop_cnt
);

   // Encoding equals occupancy; bit 1 alone marks the skid entry as valid.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   localparam logic [CNT_W+1:0] MAX_DROP = {2'b00, {CNT_W{1'b1}}};

   state_t              r_state;
   state_t              w_state_nxt;
   logic [DATA_W-1:0]   r_main_d;
   logic [DATA_W-1:0]   r_skid_d;
   logic [CNT_W-1:0]    r_drop;

   logic                w_acc_in;
   logic                w_acc_out;
   logic [1:0]          w_inc;
   logic [CNT_W+1:0]    w_sum;
   logic [CNT_W-1:0]    w_drop_nxt;

   assign w_acc_in  = valid_in & ready_out;
   assign w_acc_out = valid_out & ready_in & ~freeze;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (flush) begin
         w_state_nxt = EMPTY;
      end else begin
         unique case (r_state)
            EMPTY: begin
               if (w_acc_in) w_state_nxt = ONE;
            end
            ONE: begin
               if (w_acc_in && !w_acc_out && SKID != 0)
                  w_state_nxt = FULL;
               else if (!w_acc_in && w_acc_out)
                  w_state_nxt = EMPTY;
            end
            FULL: begin
               if (w_acc_out) w_state_nxt = ONE;
            end
            default: w_state_nxt = EMPTY;
         endcase
      end
   end

   always_comb begin
      valid_out = (r_state != EMPTY);
      count     = r_state;
      data_out  = r_main_d;
      drop_cnt  = r_drop;
      if (SKID != 0)
         ready_out = ~r_state[1];
      else
         ready_out = ~valid_out | (ready_in & ~freeze);
   end

   // Entries dropped by flush: everything held plus any incoming transfer.
   assign w_inc      = r_state + {1'b0, w_acc_in};
   assign w_sum      = {2'b00, r_drop} + {{CNT_W{1'b0}}, w_inc};
   assign w_drop_nxt = (w_sum > MAX_DROP) ? {CNT_W{1'b1}}
                                          : w_sum[CNT_W-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_main_d <= RESET_VAL;
         r_skid_d <= RESET_VAL;
         r_drop   <= '0;
      end else if (flush) begin
         r_main_d <= RESET_VAL;
         r_skid_d <= RESET_VAL;
         r_drop   <= w_drop_nxt;
      end else if (w_acc_out && r_state == FULL) begin
         r_main_d <= r_skid_d;
         r_skid_d <= RESET_VAL;
      end else if (w_acc_in && (r_state == EMPTY || w_acc_out)) begin
         r_main_d <= data_in;
      end else if (w_acc_in) begin
         r_skid_d <= data_in;
      end else if (w_acc_out) begin
         r_main_d <= RESET_VAL;
      end
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: SKID=0 and SKID=1 instances share one
// stimulus stream and are checked against a list-based occupancy model.
module tb_pipe_stage_reg;

   localparam int          DW = 16;
   localparam int          CW = 2;
   localparam logic [15:0] RV = 16'hDEAD;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          flush = 1'b0;
   logic          freeze = 1'b0;
   logic          valid_in = 1'b0;
   logic          ready_in = 1'b0;
   logic [DW-1:0] data_in = '0;

   logic          ro0, vo0, ro1, vo1;
   logic [DW-1:0] do0, do1;
   logic [1:0]    cnt0, cnt1;
   logic [CW-1:0] dc0, dc1;

   always #5 clk = ~clk;

   pipe_stage_reg #(.DATA_W(DW), .SKID(0), .RESET_VAL(RV), .CNT_W(CW)) u_d0 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .freeze(freeze),
      .valid_in(valid_in), .data_in(data_in), .ready_out(ro0),
      .valid_out(vo0), .data_out(do0), .ready_in(ready_in),
      .count(cnt0), .drop_cnt(dc0));

   pipe_stage_reg #(.DATA_W(DW), .SKID(1), .RESET_VAL(RV), .CNT_W(CW)) u_d1 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .freeze(freeze),
      .valid_in(valid_in), .data_in(data_in), .ready_out(ro1),
      .valid_out(vo1), .data_out(do1), .ready_in(ready_in),
      .count(cnt1), .drop_cnt(dc1));

   int checks = 0;
   int passed = 0;

   // Model: per instance a list of up to two held payloads and a drop tally.
   int          mn[2];
   logic [15:0] mb[2][2];
   int          md[2];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   function automatic bit mrdy(input int k);
      if (k == 1) return mn[k] < 2;
      return (mn[k] == 0) || (ready_in && !freeze);
   endfunction

   function automatic int mdata(input int k);
      return (mn[k] != 0) ? int'(mb[k][0]) : int'(RV);
   endfunction

   task automatic check_all();
      chk("d0.valid_out", int'(vo0), int'(mn[0] != 0));
      chk("d0.data_out", int'(do0), mdata(0));
      chk("d0.count", int'(cnt0), mn[0]);
      chk("d0.ready_out", int'(ro0), int'(mrdy(0)));
      chk("d0.drop_cnt", int'(dc0), md[0]);
      chk("d1.valid_out", int'(vo1), int'(mn[1] != 0));
      chk("d1.data_out", int'(do1), mdata(1));
      chk("d1.count", int'(cnt1), mn[1]);
      chk("d1.ready_out", int'(ro1), int'(mrdy(1)));
      chk("d1.drop_cnt", int'(dc1), md[1]);
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         mn[k] = 0;
         md[k] = 0;
      end
   endtask

   // Called at a negedge with inputs set; returns at the next negedge.
   task automatic step();
      bit ai[2];
      bit ao[2];
      #1 check_all();
      for (int k = 0; k < 2; k++) begin
         ai[k] = valid_in && mrdy(k);
         ao[k] = (mn[k] > 0) && ready_in && !freeze;
      end
      @(posedge clk);
      if (rst_n) begin
         for (int k = 0; k < 2; k++) begin
            if (flush) begin
               md[k] = md[k] + mn[k] + int'(ai[k]);
               if (md[k] > 3) md[k] = 3;
               mn[k] = 0;
            end else begin
               if (ao[k]) begin
                  mb[k][0] = mb[k][1];
                  mn[k]--;
               end
               if (ai[k]) begin
                  mb[k][mn[k]] = data_in;
                  mn[k]++;
               end
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic drive(input bit v, input logic [15:0] d, input bit r,
                        input bit fz, input bit fl);
      valid_in = v;
      data_in  = d;
      ready_in = r;
      freeze   = fz;
      flush    = fl;
   endtask

   initial begin
      model_reset();
      repeat (2) @(negedge clk);
      #1;
      chk("rst.valid_out", int'(vo1), 0);
      chk("rst.data_out", int'(do1), 'hDEAD);
      chk("rst.count", int'(cnt1), 0);
      chk("rst.drop_cnt", int'(dc1), 0);
      chk("rst.ready_out", int'(ro1), 1);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 1; i <= 8; i++) begin
         drive(1'b1, 16'(i), 1'b1, 1'b0, 1'b0);
         step();
         chk("stream.data", int'(do1), i);
         chk("stream.count", int'(cnt1), 1);
         chk("stream.ready", int'(ro1), 1);
      end
      drive(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
      step();

      drive(1'b1, 16'h000A, 1'b1, 1'b0, 1'b0);
      step();
      drive(1'b1, 16'h000B, 1'b0, 1'b0, 1'b0);
      step();
      drive(1'b1, 16'h000C, 1'b0, 1'b0, 1'b0);
      step();
      chk("bp.count", int'(cnt1), 2);
      chk("bp.ready", int'(ro1), 0);
      chk("bp.head", int'(do1), 'hA);
      drive(1'b1, 16'h000C, 1'b1, 1'b0, 1'b0);
      step();
      chk("bp.second", int'(do1), 'hB);
      step();
      chk("bp.third", int'(do1), 'hC);
      drive(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
      step();
      chk("bp.drained", int'(vo1), 0);

      drive(1'b1, 16'h0055, 1'b1, 1'b0, 1'b0);
      step();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 16'h0066, 1'b1, 1'b1, 1'b0);
         step();
         chk("frz.hold", int'(do1), 'h55);
      end
      chk("frz.skid_full", int'(cnt1), 2);
      drive(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
      step();
      chk("frz.next", int'(do1), 'h66);
      step();

      drive(1'b1, 16'h0001, 1'b0, 1'b0, 1'b0);
      step();
      drive(1'b1, 16'h0002, 1'b0, 1'b0, 1'b0);
      step();
      chk("fl.full", int'(cnt1), 2);
      drive(1'b1, 16'h0003, 1'b0, 1'b0, 1'b1);
      step();
      chk("fl.valid", int'(vo1), 0);
      chk("fl.data", int'(do1), 'hDEAD);
      chk("fl.count", int'(cnt1), 0);
      chk("fl.drop2", int'(dc1), 2);
      step();
      chk("fl.drop3", int'(dc1), 3);
      step();
      chk("fl.sat", int'(dc1), 3);
      drive(1'b1, 16'h0077, 1'b1, 1'b0, 1'b0);
      step();
      drive(1'b0, 16'h0, 1'b1, 1'b1, 1'b1);
      step();
      chk("fl.frz_valid", int'(vo1), 0);

      for (int i = 0; i < 16; i++) begin
         drive(1'b1, 16'(16'h100 + i), 1'(i % 2), 1'b0, 1'b0);
         step();
         chk("s0.count_le1", int'(cnt0 <= 2'd1), 1);
      end

      for (int i = 0; i < 400; i++) begin
         drive(1'($urandom_range(0, 3) != 0), 16'($urandom),
               1'($urandom_range(0, 2) != 0),
               1'($urandom_range(0, 9) == 0),
               1'($urandom_range(0, 19) == 0));
         step();
      end

      drive(1'b1, 16'h0201, 1'b1, 1'b0, 1'b0);
      step();
      drive(1'b1, 16'h0202, 1'b0, 1'b0, 1'b0);
      step();
      #2 rst_n = 1'b0;
      #1;
      chk("arst.valid", int'(vo1), 0);
      chk("arst.data", int'(do1), 'hDEAD);
      chk("arst.count", int'(cnt1), 0);
      chk("arst.drop", int'(dc1), 0);
      chk("arst.ready", int'(ro1), 1);
      chk("arst.valid0", int'(vo0), 0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 16'(16'h300 + i), 1'b1, 1'b0, 1'b0);
         step();
         chk("restart.data", int'(do1), 'h300 + i);
      end
      drive(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
      step();
      step();

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
